// File: rtl/lza_normalizer.sv
// LZA consumer: leading-one count, left normalization, 1-bit correction.
// Two-stage valid/ready pipeline between significand adder and rounding.
module lza_normalizer #(
    parameter int SWR = 26,
    parameter int SWD = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [SWR-1:0] S_i,
    input  logic [SWR-1:0] Sig_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SWR-1:0] Sig_o,
    output logic [SWD-1:0] Shift_o,
    output logic           Corr_o,
    output logic           Zero_o
);

    logic           r_s1_valid;
    logic [SWR-1:0] r_s1_sig;
    logic [SWD-1:0] r_s1_k;
    logic           r_s1_zero;

    logic           r_out_valid;
    logic [SWR-1:0] r_sig;
    logic [SWD-1:0] r_shift;
    logic           r_corr;
    logic           r_zero;

    logic           w_s2_adv;
    logic           w_s1_adv;
    logic [SWD-1:0] w_k;
    logic           w_s_zero;
    logic [SWR-1:0] w_t;
    logic [SWR-1:0] w_sig;
    logic [SWD-1:0] w_shift;
    logic           w_corr;
    logic           w_zero;

    assign w_s2_adv   = !r_out_valid || out_ready_i;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready_o = w_s1_adv;

    // Highest set bit wins since the scan runs LSB to MSB.
    always_comb begin
        w_k      = SWD'(SWR);
        w_s_zero = ~|S_i;
        for (int i = 0; i < SWR; i++) begin
            if (S_i[i]) begin
                w_k = SWD'(SWR - 1 - i);
            end
        end
    end

    // A miss by more than one position (or a zero significand) yields zero.
    always_comb begin
        w_t     = r_s1_sig << r_s1_k;
        w_sig   = '0;
        w_shift = SWD'(SWR);
        w_corr  = 1'b0;
        w_zero  = 1'b1;
        if (!r_s1_zero) begin
            if (w_t[SWR-1]) begin
                w_sig   = w_t;
                w_shift = r_s1_k;
                w_zero  = 1'b0;
            end else if (w_t[SWR-2]) begin
                w_sig   = {w_t[SWR-2:0], 1'b0};
                w_shift = r_s1_k + 1'b1;
                w_corr  = 1'b1;
                w_zero  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sig   <= '0;
            r_s1_k     <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_sig  <= Sig_i;
                r_s1_k    <= w_k;
                r_s1_zero <= w_s_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sig       <= '0;
            r_shift     <= '0;
            r_corr      <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sig   <= w_sig;
                r_shift <= w_shift;
                r_corr  <= w_corr;
                r_zero  <= w_zero;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign Sig_o       = r_sig;
    assign Shift_o     = r_shift;
    assign Corr_o      = r_corr;
    assign Zero_o      = r_zero;

endmodule

// File: tb/tb_lza_normalizer.sv
// Bench for lza_normalizer: directed vectors, backpressure, reset flush,
// and randomized traffic checked through an in-order scoreboard.
module tb_lza_normalizer;

    typedef struct packed {
        logic [25:0] sig;
        logic [4:0]  shift;
        logic        corr;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [25:0] S_i;
    logic [25:0] Sig_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [25:0] Sig_o;
    logic [4:0]  Shift_o;
    logic        Corr_o;
    logic        Zero_o;

    int   errors = 0;
    int   checks = 0;
    int   n_pop  = 0;
    bit   rnd_rdy = 1'b0;
    exp_t q[$];

    lza_normalizer #(.SWR(26), .SWD(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .S_i        (S_i),
        .Sig_i      (Sig_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .Sig_o      (Sig_o),
        .Shift_o    (Shift_o),
        .Corr_o     (Corr_o),
        .Zero_o     (Zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [25:0] sig, input int sh,
                                input bit corr, input bit zero);
        exp_t e;
        e.sig   = sig;
        e.shift = 5'(sh);
        e.corr  = corr;
        e.zero  = zero;
        return e;
    endfunction

    function automatic exp_t model(input logic [25:0] s,
                                   input logic [25:0] g);
        int          p;
        logic [25:0] t;
        exp_t        e;
        p = -1;
        e = mk(26'd0, 26, 1'b0, 1'b1);
        for (int i = 0; i < 26; i++) if (s[i]) p = i;
        if (p >= 0) begin
            t = g << (25 - p);
            if (t[25]) e = mk(t, 25 - p, 1'b0, 1'b0);
            else if (t[24]) e = mk(t << 1, 26 - p, 1'b1, 1'b0);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sig", 32'(Sig_o), 32'(e.sig));
                chk("shift", 32'(Shift_o), 32'(e.shift));
                chk("corr", 32'(Corr_o), 32'(e.corr));
                chk("zero", 32'(Zero_o), 32'(e.zero));
                n_pop++;
            end
        end
    end

    task automatic drive(input logic [25:0] s, input logic [25:0] g,
                         input exp_t e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        S_i        = s;
        Sig_i      = g;
        in_valid_i = 1'b1;
        while (!done && n < 40) begin
            @(negedge clk);
            if (in_ready_o) begin
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        in_valid_i = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int          base;
        int          p;
        int          qb;
        logic [25:0] rs;
        logic [25:0] rg;
        logic [25:0] s;
        logic [25:0] g;

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        S_i         = '0;
        Sig_i       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_sig", 32'(Sig_o), 32'd0);
        chk("rst_shift", 32'(Shift_o), 32'd0);
        chk("rst_corr", 32'(Corr_o), 32'd0);
        chk("rst_zero", 32'(Zero_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;

        out_ready_i = 1'b1;
        drive(26'h0080000, 26'h0080000, mk(26'h2000000, 6, 1'b0, 1'b0));
        drive(26'h0080000, 26'h0040000, mk(26'h2000000, 7, 1'b1, 1'b0));
        drive(26'h0000000, 26'h0000000, mk(26'h0000000, 26, 1'b0, 1'b1));
        drive(26'h2000000, 26'h3FFFFFF, mk(26'h3FFFFFF, 0, 1'b0, 1'b0));
        drive(26'h0080000, 26'h0000000, mk(26'h0000000, 26, 1'b0, 1'b1));
        drive(26'h0080000, 26'h0020000, mk(26'h0000000, 26, 1'b0, 1'b1));
        drive(26'h0000001, 26'h0000001, mk(26'h2000000, 25, 1'b0, 1'b0));
        drain();

        out_ready_i = 1'b0;
        drive(26'h0080000, 26'h0080000, mk(26'h2000000, 6, 1'b0, 1'b0));
        drive(26'h0001000, 26'h0000FFF, mk(26'h3FFC000, 14, 1'b1, 1'b0));
        S_i        = 26'h0000001;
        Sig_i      = 26'h0000001;
        in_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            chk("bp_hold_sig", 32'(Sig_o), 32'h2000000);
            chk("bp_hold_shift", 32'(Shift_o), 32'd6);
            @(posedge clk);
            #1;
        end
        base = n_pop;
        out_ready_i = 1'b1;
        drive(26'h0000001, 26'h0000001, mk(26'h2000000, 25, 1'b0, 1'b0));
        drive(26'h0000003, 26'h0000000, mk(26'h0000000, 26, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_burst_count", 32'(n_pop - base), 32'd4);
        drain();

        out_ready_i = 1'b0;
        drive(26'h0080000, 26'h0080000, mk(26'h2000000, 6, 1'b0, 1'b0));
        drive(26'h2000000, 26'h3FFFFFF, mk(26'h3FFFFFF, 0, 1'b0, 1'b0));
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid_o), 32'd0);
        chk("flush_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        base = n_pop;
        drive(26'h0080000, 26'h0040000, mk(26'h2000000, 7, 1'b1, 1'b0));
        drain();
        chk("flush_single_out", 32'(n_pop - base), 32'd1);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                out_ready_i = 1'($urandom_range(0, 1));
            end
            p  = $urandom_range(0, 25);
            qb = (p > 0 && $urandom_range(0, 1) == 1) ? p - 1 : p;
            rs = 26'($urandom);
            rg = 26'($urandom);
            s  = (26'd1 << p) | (rs & ((26'd1 << p) - 26'd1));
            g  = (26'd1 << qb) | (rg & ((26'd1 << qb) - 26'd1));
            if ($urandom_range(0, 15) == 0) s = '0;
            if ($urandom_range(0, 15) == 0) g = '0;
            drive(s, g, model(s, g));
        end
        rnd_rdy     = 1'b0;
        out_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
